// File: rtl/alu_share_pkg.sv
// alu_share_pkg: state encoding, op-field layout and default width
// for the shared ALU controller.
package alu_share_pkg;

    localparam int DEF_WIDTH = 32;

    localparam int OP_A_OR_L = 2;
    localparam int OP_S_OR_U = 1;
    localparam int OP_OPCODE = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arb.sv
// alu_share_arb: combinational two-way grant (0 = req0, 1 = req1).
// ALU_SHARE_RR_EN: round-robin ties; otherwise req0 has fixed priority.
module alu_share_arb
    import alu_share_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant
);

`ifdef ALU_SHARE_RR_EN
    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else begin
            grant = valid1;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = 1'b0;
        if (!valid0) begin
            grant = valid1;
        end
    end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one combinational ALU,
// holds operands for EXEC_CYCLES, returns the result. Macro: ALU_SHARE_RR_EN.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int EXEC_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_a_or_l,
    output logic             alu_s_or_u,
    output logic             alu_opcode,
    input  logic [WIDTH-1:0] alu_answer,
    output logic             busy
);

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       owner;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic       rsp_hit;
    logic [2:0] op_sel;

    alu_share_arb u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // rst_n gates ready so nothing looks accepted while reset is held
    assign accept     = (state == IDLE) && rst_n && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign rsp_hit    = owner ? rsp1_ready : rsp0_ready;
    assign busy       = (state != IDLE);
    assign op_sel     = grant ? req1_op : req0_op;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (cnt == '0) state_nxt = RESP;
            RESP:    if (rsp_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_a_or_l <= 1'b0;
            alu_s_or_u <= 1'b0;
            alu_opcode <= 1'b0;
            rsp_data   <= '0;
        end else begin
            if (accept) begin
                owner      <= grant;
                cnt        <= CNT_INIT;
                alu_a      <= grant ? req1_a : req0_a;
                alu_b      <= grant ? req1_b : req0_b;
                alu_a_or_l <= op_sel[OP_A_OR_L];
                alu_s_or_u <= op_sel[OP_S_OR_U];
                alu_opcode <= op_sel[OP_OPCODE];
            end
            if (state == EXEC) begin
                if (cnt == '0) begin
                    rsp_data <= alu_answer;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
            if ((state == RESP) && rsp_hit) begin
                last_grant <= owner;
            end
        end
    end

endmodule
